// File: rtl/cpu_pkg.sv
// cpu_pkg: RV32 load/store funct3 encodings and memory-stage FSM states shared by the core.
package cpu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} mem_state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication / byte enables and load lane extraction / extension.
module mem_align
   import cpu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] ldata_o
);
   logic        is_b, is_h, sx;
   logic [1:0]  eo;
   logic [31:0] sh;
   assign is_b = funct3_i[1:0] == F3_B[1:0];
   assign is_h = funct3_i[1:0] == F3_H[1:0];
   // Unsigned variants have funct3[2] set; reserved encodings fall through to word access.
   assign sx = !funct3_i[2];
   assign eo = is_b ? off_i : is_h ? {off_i[1], 1'b0} : 2'b00;
   assign wdata_o = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
   assign be_o = is_b ? 4'b0001 << eo : is_h ? 4'b0011 << eo : 4'b1111;
   assign sh = rdata_i >> {eo, 3'b000};
   assign ldata_o = is_b ? {{24{sx & sh[7]}}, sh[7:0]} :
                    is_h ? {{16{sx & sh[15]}}, sh[15:0]} : rdata_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage driving a req/gnt/rvalid data port with timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating the offset.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int RSP_TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_y_in,
   input  logic [31:0] rs2_val_in,
   input  logic [4:0]  rd_in,
   input  logic [2:0]  funct3_in,
   input  logic        memRead_in,
   input  logic        memWrite_in,
   input  logic        regWrite_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_regWrite,
   output logic        mem_stall,
   output logic        misalign,
   output logic        bus_err
);
   localparam int CW = $clog2(RSP_TIMEOUT + 1);
   mem_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_op, is_load, mis, tmo, req, stall, berr;
   logic [3:0]    be;
   logic [31:0]   ld_data;
   assign is_load = memRead_in;
   assign mem_op  = memRead_in | memWrite_in;
   assign tmo     = cnt_q == CW'(RSP_TIMEOUT);
`ifdef MEM_MISALIGN_TRAP_EN
   assign mis = mem_op && ((funct3_in[1:0] == F3_H[1:0] && alu_y_in[0]) ||
                           (funct3_in[1] && alu_y_in[1:0] != 2'b00));
`else
   assign mis = 1'b0;
`endif
   mem_align u_align (
      .funct3_i (funct3_in),
      .off_i    (alu_y_in[1:0]),
      .wdata_i  (rs2_val_in),
      .rdata_i  (dmem_rdata),
      .wdata_o  (dmem_wdata),
      .be_o     (be),
      .ldata_o  (ld_data)
   );
   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      stall   = 1'b0;
      berr    = 1'b0;
      case (state_q)
         IDLE: if (mem_op && !mis) begin
            req     = 1'b1;
            stall   = !dmem_gnt || is_load;
            state_d = !dmem_gnt ? WAIT_GNT : is_load ? WAIT_RSP : IDLE;
         end
         // Timeout wins over a late gnt: the request is withdrawn in that cycle.
         WAIT_GNT: begin
            req     = !tmo;
            berr    = tmo;
            stall   = !tmo && (!dmem_gnt || is_load);
            state_d = tmo ? IDLE : !dmem_gnt ? WAIT_GNT : is_load ? WAIT_RSP : IDLE;
         end
         WAIT_RSP: begin
            berr    = tmo;
            stall   = !tmo && !dmem_rvalid;
            state_d = (tmo || dmem_rvalid) ? IDLE : WAIT_RSP;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = (state_q != IDLE && state_d == state_q) ? cnt_q + 1'b1 : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign dmem_req    = req && !rst;
   assign dmem_we     = dmem_req && !is_load;
   assign dmem_be     = dmem_req ? be : 4'b0000;
   assign dmem_addr   = {alu_y_in[31:2], 2'b00};
   assign mem_stall   = stall && !rst;
   assign bus_err     = berr && !rst;
   assign misalign    = mis && state_q == IDLE && !rst;
   assign wb_data     = is_load ? ld_data : alu_y_in;
   assign wb_rd       = rd_in;
   assign wb_regWrite = regWrite_in && !misalign && !bus_err && !rst;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a byte-level model.
module tb_mem_stage;
   localparam int TO = 255;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] alu_y_in = '0, rs2_val_in = '0, dmem_rdata = '0;
   logic [4:0]  rd_in = '0;
   logic [2:0]  funct3_in = '0;
   logic        memRead_in = 1'b0, memWrite_in = 1'b0, regWrite_in = 1'b0;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic        dmem_req, dmem_we, wb_regWrite, mem_stall, misalign, bus_err;
   logic [31:0] dmem_addr, dmem_wdata, wb_data;
   logic [3:0]  dmem_be;
   logic [4:0]  wb_rd;
   int checks = 0, errors = 0;
   typedef struct {
      int stalls;
      bit done, req_seen, stable, berr, mis, we;
      logic [31:0] addr, wdata, wb;
      logic [3:0] be;
      logic wrw;
      logic [4:0] wrd;
   } obs_t;
   always #5 clk = ~clk;
   mem_stage #(.RSP_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .alu_y_in(alu_y_in), .rs2_val_in(rs2_val_in), .rd_in(rd_in),
      .funct3_in(funct3_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
      .regWrite_in(regWrite_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
      .mem_stall(mem_stall), .misalign(misalign), .bus_err(bus_err)
   );
   function automatic int sz(input logic [2:0] f3);
      return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
   endfunction
   function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
      return (a % sz(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction
   function automatic int eoff(input logic [2:0] f3, input logic [31:0] a);
      int o = int'(a % 4);
      return o - o % sz(f3);
   endfunction
   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] b = '0;
      for (int i = 0; i < 4; i++) b[i] = i >= eoff(f3, a) && i < eoff(f3, a) + sz(f3);
      return b;
   endfunction
   function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz(f3)) +: 8];
      return w;
   endfunction
   function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v = '0;
      int s = sz(f3);
      for (int j = 0; j < s; j++) v[8*j +: 8] = rd[8*(eoff(f3, a) + j) +: 8];
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8*s-1])
         for (int j = 8*s; j < 32; j++) v[j] = 1'b1;
      return v;
   endfunction
   // Drives one EX/MEM op until the stage stops stalling; gd/rsd are gnt/rvalid delays in cycles.
   task automatic run_op(input bit ld, input bit st, input bit rw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input logic [4:0] rd, input int gd, input int rsd, output obs_t r);
      int k = 0;
      bit ph = 0, fin;
      r.stalls = 0; r.done = 0; r.req_seen = 0; r.stable = 1; r.berr = 0; r.mis = 0; r.we = 0;
      r.addr = '0; r.wdata = '0; r.be = '0; r.wb = '0; r.wrw = 0; r.wrd = '0;
      memRead_in = ld; memWrite_in = st; regWrite_in = rw; funct3_in = f3;
      alu_y_in = a; rs2_val_in = wd; dmem_rdata = rdat; rd_in = rd;
      for (int c = 0; c < 600; c++) begin
         dmem_gnt = !ph && k == gd;
         dmem_rvalid = ph && k == rsd;
         @(negedge clk);
         if (dmem_req) begin
            if (!r.req_seen) begin
               r.req_seen = 1; r.addr = dmem_addr; r.wdata = dmem_wdata; r.be = dmem_be; r.we = dmem_we;
            end else if (dmem_addr !== r.addr || dmem_wdata !== r.wdata || dmem_be !== r.be || dmem_we !== r.we)
               r.stable = 0;
         end
         r.berr |= bus_err;
         r.mis |= misalign;
         fin = !mem_stall;
         if (mem_stall) r.stalls++;
         if (fin) begin
            r.done = 1; r.wb = wb_data; r.wrw = wb_regWrite; r.wrd = wb_rd;
         end
         @(posedge clk); #1;
         if (fin) break;
         if (!ph && dmem_gnt && ld) begin ph = 1; k = 0; end
         else k++;
      end
      dmem_gnt = 0; dmem_rvalid = 0; memRead_in = 0; memWrite_in = 0; regWrite_in = 0;
   endtask
   task automatic test_reset;
      memRead_in = 1; regWrite_in = 1; funct3_in = 3'b010; alu_y_in = 32'h100;
      @(posedge clk); #1;
      @(negedge clk);
      checks += 4;
      if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dmem_req); end
      if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mem_stall); end
      if (wb_regWrite !== 1'b0) begin errors++; $display("FAIL reset_wbrw got %b want 0", wb_regWrite); end
      if ({dmem_we, dmem_be, misalign, bus_err} !== 7'b0) begin
         errors++; $display("FAIL reset_misc got %b want 0", {dmem_we, dmem_be, misalign, bus_err});
      end
      @(posedge clk); #1;
      rst = 0; memRead_in = 0; regWrite_in = 0;
   endtask
   task automatic test_store;
      obs_t r;
      run_op(0, 1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 5'd3, 0, 0, r);
      checks += 5;
      if (r.addr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h want 00000100", r.addr); end
      if (r.be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", r.be); end
      if (r.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", r.wdata); end
      if (r.stalls !== 0) begin errors++; $display("FAIL sw_stall got %0d want 0", r.stalls); end
      if (r.we !== 1'b1) begin errors++; $display("FAIL sw_we got %b want 1", r.we); end
   endtask
   task automatic test_load_lb;
      obs_t r;
      run_op(1, 0, 1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 5'd7, 0, 1, r);
      checks += 4;
      if (r.stalls !== 2) begin errors++; $display("FAIL lb_stall got %0d want 2", r.stalls); end
      if (r.wb !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", r.wb); end
      if (r.wrw !== 1'b1 || r.wrd !== 5'd7) begin errors++; $display("FAIL lb_wb got %b/%0d want 1/7", r.wrw, r.wrd); end
      if (r.we !== 1'b0) begin errors++; $display("FAIL lb_we got %b want 0", r.we); end
   endtask
   task automatic test_lhu_sb;
      obs_t r;
      run_op(1, 0, 1, 3'b101, 32'h202, 32'h0, 32'hBEEF1234, 5'd9, 0, 0, r);
      checks += 2;
      if (r.wb !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data got %h want 0000beef", r.wb); end
      if (r.stalls !== 1) begin errors++; $display("FAIL lhu_stall got %0d want 1", r.stalls); end
      run_op(0, 1, 0, 3'b000, 32'h201, 32'h000000AB, 32'h0, 5'd0, 0, 0, r);
      checks += 2;
      if (r.be !== 4'b0010) begin errors++; $display("FAIL sb_be got %b want 0010", r.be); end
      if (r.wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h want abababab", r.wdata); end
   endtask
   task automatic test_timeout;
      obs_t r;
      run_op(1, 0, 1, 3'b010, 32'h400, 32'h0, 32'h1234, 5'd4, 3, 100000, r);
      checks += 5;
      if (!r.done) begin errors++; $display("FAIL to_done got 0 want 1"); end
      if (!r.stable) begin errors++; $display("FAIL to_stable got 0 want 1"); end
      if (!r.berr) begin errors++; $display("FAIL to_buserr got 0 want 1"); end
      if (r.wrw !== 1'b0) begin errors++; $display("FAIL to_wbrw got %b want 0", r.wrw); end
      if (r.stalls !== 4 + TO) begin errors++; $display("FAIL to_stall got %0d want %0d", r.stalls, 4 + TO); end
      @(negedge clk);
      checks++;
      if (bus_err !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL to_pulse got %b%b want 00", bus_err, mem_stall);
      end
      @(posedge clk); #1;
      run_op(0, 1, 0, 3'b010, 32'h500, 32'h55, 32'h0, 5'd0, 0, 0, r);
      checks++;
      if (r.stalls !== 0 || !r.req_seen) begin errors++; $display("FAIL to_idle got %0d/%b want 0/1", r.stalls, r.req_seen); end
   endtask
   task automatic test_misalign;
      obs_t r;
      run_op(1, 0, 1, 3'b010, 32'h301, 32'h0, 32'hCAFEF00D, 5'd5, 0, 0, r);
      checks += 3;
`ifdef MEM_MISALIGN_TRAP_EN
      if (!r.mis || r.req_seen) begin errors++; $display("FAIL mis_pulse got %b/%b want 1/0", r.mis, r.req_seen); end
      if (r.wrw !== 1'b0) begin errors++; $display("FAIL mis_wbrw got %b want 0", r.wrw); end
      if (r.stalls !== 0) begin errors++; $display("FAIL mis_stall got %0d want 0", r.stalls); end
`else
      if (r.addr !== 32'h300 || r.mis) begin errors++; $display("FAIL lw_addr got %h/%b want 00000300/0", r.addr, r.mis); end
      if (r.wb !== 32'hCAFEF00D) begin errors++; $display("FAIL lw_data got %h want cafef00d", r.wb); end
      if (r.stalls !== 1) begin errors++; $display("FAIL lw_stall got %0d want 1", r.stalls); end
`endif
   endtask
   task automatic test_reset_mid;
      obs_t r;
      memRead_in = 1; regWrite_in = 1; funct3_in = 3'b010; alu_y_in = 32'h600; dmem_gnt = 1;
      @(posedge clk); #1;
      dmem_gnt = 0;
      @(negedge clk);
      checks++;
      if (mem_stall !== 1'b1) begin errors++; $display("FAIL rm_wait got %b want 1", mem_stall); end
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      checks++;
      if ({dmem_req, dmem_we, dmem_be, mem_stall, misalign, bus_err, wb_regWrite} !== 10'b0) begin
         errors++; $display("FAIL rm_outs got %b want 0", {dmem_req, dmem_we, dmem_be, mem_stall, misalign, bus_err, wb_regWrite});
      end
      @(posedge clk); #1;
      rst = 0; memRead_in = 0; regWrite_in = 0; dmem_rvalid = 1; alu_y_in = 32'h55;
      @(negedge clk);
      checks++;
      if (mem_stall !== 1'b0 || dmem_req !== 1'b0 || wb_data !== 32'h55) begin
         errors++; $display("FAIL rm_late got %b/%b/%h want 0/0/00000055", mem_stall, dmem_req, wb_data);
      end
      @(posedge clk); #1;
      dmem_rvalid = 0;
      run_op(1, 0, 1, 3'b100, 32'h702, 32'h0, 32'h00F10000, 5'd2, 1, 0, r);
      checks++;
      if (r.wb !== 32'h000000F1 || r.stalls !== 2) begin
         errors++; $display("FAIL rm_next got %h/%0d want 000000f1/2", r.wb, r.stalls);
      end
   endtask
   task automatic test_random;
      obs_t r;
      int kind, gd, rsd, es;
      bit ld, st, rw, mem, m;
      logic [2:0] f3;
      logic [31:0] a, wd, rdat;
      logic [4:0] rd;
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 3); ld = kind == 1 || kind == 3; st = kind == 2 || kind == 3;
         rw = 1'($urandom); f3 = 3'($urandom); a = $urandom; wd = $urandom; rdat = $urandom; rd = 5'($urandom);
         gd = $urandom_range(0, 3); rsd = $urandom_range(0, 3);
         mem = ld || st; m = mem && is_mis(f3, a);
         es = (!mem || m) ? 0 : ld ? gd + 1 + rsd : gd;
         run_op(ld, st, rw, f3, a, wd, rdat, rd, gd, rsd, r);
         checks += 5;
         if (r.stalls !== es) begin errors++; $display("FAIL rnd%0d_stall got %0d want %0d", n, r.stalls, es); end
         if (r.wrw !== (rw && !m) || r.wrd !== rd) begin errors++; $display("FAIL rnd%0d_wb got %b/%0d want %b/%0d", n, r.wrw, r.wrd, rw && !m, rd); end
         if (r.mis !== m) begin errors++; $display("FAIL rnd%0d_mis got %b want %b", n, r.mis, m); end
         if (r.req_seen !== (mem && !m)) begin errors++; $display("FAIL rnd%0d_req got %b want %b", n, r.req_seen, mem && !m); end
         if (!m && r.wb !== (ld ? exp_ld(f3, a, rdat) : a)) begin
            errors++; $display("FAIL rnd%0d_data got %h want %h", n, r.wb, ld ? exp_ld(f3, a, rdat) : a);
         end
         if (mem && !m) begin
            checks += 2;
            if (r.addr !== {a[31:2], 2'b00} || r.we !== !ld) begin
               errors++; $display("FAIL rnd%0d_addr got %h/%b want %h/%b", n, r.addr, r.we, {a[31:2], 2'b00}, !ld);
            end
            if (!r.stable) begin errors++; $display("FAIL rnd%0d_stable got 0 want 1", n); end
            if (!ld) begin
               checks++;
               if (r.be !== exp_be(f3, a) || r.wdata !== exp_wd(f3, wd)) begin
                  errors++; $display("FAIL rnd%0d_store got %b/%h want %b/%h", n, r.be, r.wdata, exp_be(f3, a), exp_wd(f3, wd));
               end
            end
         end
      end
   endtask
   initial begin
      test_reset;
      test_store;
      test_load_lb;
      test_lhu_sb;
      test_timeout;
      test_misalign;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32 core, between the EX/MEM pipeline register and the MEM/WB register. It turns the EX/MEM load/store controls into a request/grant/response transaction on the data-memory port. It formats store data and byte enables, and aligns and sign/zero-extends load data. It stalls the upstream pipeline until the access completes.

## Interface
Parameters:
- RSP_TIMEOUT, 255 — maximum cycles spent in WAIT_GNT or WAIT_RSP before the access is abandoned with bus_err.

Ports:
- clk  in  1  — single clock; all state updates on posedge.
- rst  in  1  — synchronous, active-high reset.
- alu_y_in  in  32  — effective address, or ALU result for non-memory ops.
- rs2_val_in  in  32  — store data.
- rd_in  in  5  — destination register.
- funct3_in  in  3  — access size/sign.
- memRead_in, memWrite_in, regWrite_in  in  1 each  — EX/MEM controls.
- dmem_req  out  1  — request valid.
- dmem_we  out  1  — 1 = store.
- dmem_addr  out  32  — word-aligned address ({alu_y[31:2],2'b00}).
- dmem_wdata  out  32  — lane-replicated store data.
- dmem_be  out  4  — byte enables.
- dmem_gnt  in  1  — request accepted this cycle.
- dmem_rvalid  in  1  — load response valid.
- dmem_rdata  in  32  — load response word.
- wb_data  out  32  — value for MEM/WB (load result or alu_y_in).
- wb_rd  out  5  — equals rd_in.
- wb_regWrite  out  1  — write-back enable.
- mem_stall  out  1  — freeze PC, IF/ID, ID/EX and EX/MEM.
- misalign  out  1  — misaligned access pulse (macro-dependent).
- bus_err  out  1  — timeout pulse.

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RSP. Reset and idle state is IDLE.
- A memory op is memRead_in|memWrite_in. If both are set, the op is treated as a load.
- IDLE with a memory op: dmem_req=1 combinationally.
  - gnt in the same cycle: store completes; load goes to WAIT_RSP.
  - No gnt: go to WAIT_GNT.
- WAIT_GNT: dmem_req held with identical addr/we/wdata/be. On gnt: store → IDLE, load → WAIT_RSP.
- WAIT_RSP: dmem_req=0. On rvalid: wb_data = formatted rdata; → IDLE.
- mem_stall=1 whenever a memory op is in progress and is not completing this cycle. The completion cycle has mem_stall=0, so EX/MEM advances and MEM/WB captures wb_*.
- Non-memory op: wb_data=alu_y_in, no bus activity, no stall.
- Byte offset off=alu_y_in[1:0].
- Store formatting:
  - SB(000): wdata={4{rs2[7:0]}}, be=0001<<off.
  - SH(001): wdata={2{rs2[15:0]}}, be=0011<<off.
  - SW(010): wdata=rs2, be=1111.
- Load formatting: LB/LH sign-extend the selected lane, LBU(100)/LHU(101) zero-extend, LW returns the word.
- Reserved funct3 (011, 110, 111) are treated as word access.
- wb_regWrite=regWrite_in, except 0 in a cycle that signals misalign or bus_err.
- Timeout: a counter clears on entering WAIT_GNT/WAIT_RSP and increments each cycle in those states.
  - When it reaches RSP_TIMEOUT: bus_err pulses 1 cycle, dmem_req drops, stall releases, wb_regWrite=0, FSM → IDLE.
- dmem_rvalid in IDLE or WAIT_GNT is ignored.

## Timing
- Reset values: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_be=0, mem_stall=0, misalign=0, bus_err=0, wb_regWrite=0 while rst is high.
- Reset mid-transaction abandons the access; a late rvalid after reset is ignored.
- Store with same-cycle gnt: 0 stall cycles.
- Load with same-cycle gnt and next-cycle rvalid: 1 stall cycle.
- Every cycle spent waiting for gnt or rvalid adds one stall cycle.
- gnt and rvalid are never expected in the same cycle for one access. rvalid in the gnt cycle is ignored.
- Inputs must be held stable by upstream while mem_stall=1.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned means LH/LHU/SH with off[0]=1, or LW/SW with off≠0.
  - A misaligned access issues no request and pulses misalign for 1 cycle.
  - wb_regWrite=0 and there is no stall for that access.
- MEM_MISALIGN_TRAP_EN undefined:
  - misalign is tied 0.
  - Halfword accesses use off&2'b10; word accesses use off=0 (low bits ignored).

## Structure
- Shared cpu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - typedef enum mem_state_t {IDLE, WAIT_GNT, WAIT_RSP}.
- Sub-module mem_align (combinational) holds store lane replication/byte enables and load extraction/extension. It is instantiated once, and the FSM and timeout counter stay in mem_stage.

## Test plan
- SW addr 0x100, rs2 0xDEADBEEF, gnt same cycle → dmem_addr=0x100, be=1111, wdata=0xDEADBEEF; mem_stall never asserts.
- LB addr 0x103, gnt cycle 0, rvalid cycle 2 with rdata 0x80FF_0000 → mem_stall high cycles 0–1, wb_data=0xFFFFFF80 in cycle 2.
- LHU addr 0x202, rdata 0xBEEF1234 → wb_data=0x0000BEEF. SB addr 0x201 rs2 0xAB → be=0010, wdata=0xABABABAB.
- Load with gnt withheld 3 cycles → request fields stable across all 3 cycles. Then withhold rvalid for RSP_TIMEOUT cycles → bus_err 1-cycle pulse, wb_regWrite=0, FSM returns to IDLE.
- LW addr 0x301 → with macro: misalign pulse, no dmem_req, wb_regWrite=0. Without macro: dmem_addr=0x300, normal completion.
- rst asserted while in WAIT_RSP, then rvalid the next cycle → all outputs 0, rvalid ignored, next op starts cleanly from IDLE.
